// File: rtl/util_axis_seq_checker.sv
// util_axis_seq_checker: AXI-Stream sink that checks an incrementing count under LFSR-driven back-pressure
module util_axis_seq_checker #(
   parameter int          BUS_WIDTH  = 1,
   parameter bit          READY_MODE = 1'b0,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                   aclk,
   input  logic                   arstn,
   input  logic                   enable,
   input  logic                   clear,
   input  logic [BUS_WIDTH*8-1:0] s_axis_tdata,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   output logic                   locked,
   output logic                   error,
   output logic [31:0]            err_count,
   output logic [31:0]            beat_count,
   output logic [BUS_WIDTH*8-1:0] err_expected,
   output logic [BUS_WIDTH*8-1:0] err_received
);
   localparam int DW = BUS_WIDTH * 8;
   localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam logic [DW-1:0] ONE = DW'(1);

   typedef enum logic [1:0] {IDLE, SYNC, CHECK} state_t;
   state_t state, state_nxt;

   logic [15:0]   lfsr, lfsr_nxt;
   logic [DW-1:0] expected;
   logic          beat, mismatch;

   assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   // a handshake on a clear or disabled edge is consumed but not counted
   assign beat     = s_axis_tvalid & s_axis_tready & enable & ~clear & (state != IDLE);
   assign mismatch = (state == CHECK) & (s_axis_tdata != expected);

   always_ff @(posedge aclk or negedge arstn)
      if (!arstn) state <= IDLE;
      else state <= state_nxt;

   always_comb begin
      state_nxt = state;
      if (clear) state_nxt = enable ? SYNC : IDLE;
      else if (!enable) state_nxt = IDLE;
      else if (state == IDLE) state_nxt = SYNC;
      else if (state == SYNC && beat) state_nxt = CHECK;
   end

   always_ff @(posedge aclk or negedge arstn)
      if (!arstn) begin
         lfsr          <= SEED;
         s_axis_tready <= 1'b0;
         locked        <= 1'b0;
         error         <= 1'b0;
         err_count     <= '0;
         beat_count    <= '0;
         err_expected  <= '0;
         err_received  <= '0;
         expected      <= '0;
      end else begin
         if (enable) lfsr <= lfsr_nxt;
         s_axis_tready <= enable & ~clear & (READY_MODE ? lfsr[0] : 1'b1);
         if (clear) begin
            locked       <= 1'b0;
            error        <= 1'b0;
            err_count    <= '0;
            beat_count   <= '0;
            err_expected <= '0;
            err_received <= '0;
         end else if (!enable) begin
            locked <= 1'b0;
         end else if (beat) begin
            // a mismatch resyncs too, so one skipped value costs exactly one error
            expected   <= s_axis_tdata + ONE;
            locked     <= 1'b1;
            beat_count <= (state == SYNC) ? 32'd1 : (&beat_count) ? beat_count : beat_count + 32'd1;
            if (mismatch) begin
               error     <= 1'b1;
               err_count <= (&err_count) ? err_count : err_count + 32'd1;
               if (!error) begin
                  err_expected <= expected;
                  err_received <= s_axis_tdata;
               end
            end
         end
      end
endmodule

// File: tb/tb_util_axis_seq_checker.sv
// tb_util_axis_seq_checker: random and directed stimulus against a beat-level reference model
module tb_util_axis_seq_checker;
   logic        tb_data_clk = 1'b0;
   logic        arstn = 1'b0;
   logic        en = 1'b0;
   logic        clr = 1'b0;
   logic        sel = 1'b0;
   logic        valid = 1'b0;
   logic [7:0]  data = 8'h00;
   logic        en0, en1;
   logic        rdy0, rdy1, lock0, lock1, err0, err1;
   logic [31:0] ec0, ec1, bc0, bc1;
   logic [7:0]  ce0, ce1, cr0, cr1;
   logic        o_rdy, o_lock, o_err;
   logic [31:0] o_ec, o_bc;
   logic [7:0]  o_ce, o_cr;

   int total = 0;
   int bad = 0;

   logic        mode;
   logic        m_rdy, m_lock, m_err, m_hs;
   logic [31:0] m_ec, m_bc;
   logic [7:0]  m_ce, m_cr, m_exp;
   logic [15:0] m_lfsr;

   always #5 tb_data_clk = ~tb_data_clk;

   assign en0 = en & ~sel;
   assign en1 = en & sel;
   assign o_rdy  = sel ? rdy1 : rdy0;
   assign o_lock = sel ? lock1 : lock0;
   assign o_err  = sel ? err1 : err0;
   assign o_ec   = sel ? ec1 : ec0;
   assign o_bc   = sel ? bc1 : bc0;
   assign o_ce   = sel ? ce1 : ce0;
   assign o_cr   = sel ? cr1 : cr0;

   util_axis_seq_checker #(.BUS_WIDTH(1), .READY_MODE(1'b0), .LFSR_SEED(16'hACE1)) dut0 (
      .aclk(tb_data_clk), .arstn(arstn), .enable(en0), .clear(clr),
      .s_axis_tdata(data), .s_axis_tvalid(valid), .s_axis_tready(rdy0),
      .locked(lock0), .error(err0), .err_count(ec0), .beat_count(bc0),
      .err_expected(ce0), .err_received(cr0));

   util_axis_seq_checker #(.BUS_WIDTH(1), .READY_MODE(1'b1), .LFSR_SEED(16'hACE1)) dut1 (
      .aclk(tb_data_clk), .arstn(arstn), .enable(en1), .clear(clr),
      .s_axis_tdata(data), .s_axis_tvalid(valid), .s_axis_tready(rdy1),
      .locked(lock1), .error(err1), .err_count(ec1), .beat_count(bc1),
      .err_expected(ce1), .err_received(cr1));

   function automatic logic [31:0] sat(input logic [31:0] x);
      return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic mreset();
      m_rdy = 0; m_lock = 0; m_err = 0; m_hs = 0;
      m_ec = 0; m_bc = 0; m_ce = 0; m_cr = 0; m_exp = 0;
      m_lfsr = 16'hACE1;
   endtask

   task automatic check_all();
      chk("tready", {31'b0, o_rdy}, {31'b0, m_rdy});
      chk("locked", {31'b0, o_lock}, {31'b0, m_lock});
      chk("error", {31'b0, o_err}, {31'b0, m_err});
      chk("err_count", o_ec, m_ec);
      chk("beat_count", o_bc, m_bc);
      chk("err_expected", {24'b0, o_ce}, {24'b0, m_ce});
      chk("err_received", {24'b0, o_cr}, {24'b0, m_cr});
   endtask

   // one clock: drive, advance the model by the stream rules, then compare
   task automatic cyc(input logic v, input logic [7:0] d);
      valid = v;
      data = d;
      @(posedge tb_data_clk);
      m_hs = v & m_rdy;
      if (clr) begin
         m_lock = 0; m_err = 0; m_ec = 0; m_bc = 0; m_ce = 0; m_cr = 0;
      end else if (!en) begin
         m_lock = 0;
      end else if (m_hs) begin
         if (m_lock && d != m_exp) begin
            if (!m_err) begin
               m_ce = m_exp;
               m_cr = d;
            end
            m_err = 1;
            m_ec = sat(m_ec);
         end
         m_bc = m_lock ? sat(m_bc) : 32'd1;
         m_lock = 1;
         m_exp = d + 8'd1;
      end
      m_rdy = en & ~clr & (mode ? m_lfsr[0] : 1'b1);
      if (en) m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
      #1 check_all();
   endtask

   task automatic send(input logic [7:0] d);
      int n = 0;
      do begin
         cyc(1'b1, d);
         n++;
      end while (!m_hs && n < 100);
      chk("send_timeout", {31'b0, m_hs}, 32'd1);
   endtask

   task automatic pulse_clear();
      clr = 1'b1;
      cyc(1'b0, 8'h00);
      clr = 1'b0;
   endtask

   initial begin
      mode = 1'b0;
      mreset();
      repeat (2) @(posedge tb_data_clk);
      #1 check_all();
      arstn = 1'b1;

      // continuous count with wrap
      en = 1'b1;
      for (int i = 0; i < 300; i++) send(8'(i));
      chk("t1_beats", o_bc, 32'd300);
      chk("t1_error", {31'b0, o_err}, 32'd0);
      chk("t1_locked", {31'b0, o_lock}, 32'd1);

      // single skip
      pulse_clear();
      begin
         logic [7:0] seq [6] = '{8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
         foreach (seq[i]) send(seq[i]);
      end
      chk("t2_error", {31'b0, o_err}, 32'd1);
      chk("t2_err_count", o_ec, 32'd1);
      chk("t2_err_expected", {24'b0, o_ce}, 32'd8);
      chk("t2_err_received", {24'b0, o_cr}, 32'd9);
      chk("t2_beats", o_bc, 32'd6);

      // lock on arbitrary start value
      pulse_clear();
      send(8'h42);
      chk("t4_first_beats", o_bc, 32'd1);
      chk("t4_first_error", {31'b0, o_err}, 32'd0);
      send(8'h43);
      send(8'h44);
      chk("t4_beats", o_bc, 32'd3);
      chk("t4_error", {31'b0, o_err}, 32'd0);

      // clear coinciding with a handshake
      send(8'h45);
      send(8'h47);
      clr = 1'b1;
      cyc(1'b1, 8'h48);
      clr = 1'b0;
      chk("t5_hs_on_clear", {31'b0, m_hs}, 32'd1);
      chk("t5_beats", o_bc, 32'd0);
      chk("t5_err_count", o_ec, 32'd0);
      chk("t5_error", {31'b0, o_err}, 32'd0);
      chk("t5_locked", {31'b0, o_lock}, 32'd0);
      send(8'($urandom));
      chk("t5_relock", {31'b0, o_lock}, 32'd1);
      chk("t5_relock_error", {31'b0, o_err}, 32'd0);
      chk("t5_relock_beats", o_bc, 32'd1);

      // random gaps and random corruptions
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(3) == 0) cyc(1'b0, 8'($urandom));
         send(($urandom_range(7) == 0) ? 8'($urandom) : m_exp);
      end

      // asynchronous reset between edges
      #2 arstn = 1'b0;
      mreset();
      #1 check_all();
      #2 arstn = 1'b1;
      send(8'h10);
      chk("t6_relock", {31'b0, o_lock}, 32'd1);
      chk("t6_beats", o_bc, 32'd1);
      send(8'h11);
      chk("t6_error", {31'b0, o_err}, 32'd0);

      // LFSR back-pressure on the second instance
      en = 1'b0;
      cyc(1'b0, 8'h00);
      sel = 1'b1;
      mode = 1'b1;
      mreset();
      en = 1'b1;
      for (int i = 0; i < 1000; i++) send(8'(i));
      chk("t3_beats", o_bc, 32'd1000);
      chk("t3_error", {31'b0, o_err}, 32'd0);
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 8'hE8);
         chk("t3_ready_off", {31'b0, o_rdy}, 32'd0);
      end
      chk("t3_beats_held", o_bc, 32'd1000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/util_axis_seq_checker.md
Name: util_axis_seq_checker

Overview:
- AXI-Stream sink that consumes a stream and verifies it is a monotonically incrementing count, wrapping modulo 2^(8*BUS_WIDTH).
- Generates programmable back-pressure on s_axis_tready from an LFSR, so the upstream source and any FIFO between them are exercised under stall.
- Sits at the master end of util_axis_tiny_fifo and other stream blocks, both in benches and in on-chip loopback self-test.
- Reports lock, sticky error, error and beat counters, and a capture of the first mismatch.

Parameters:
- BUS_WIDTH, 1, data width in bytes; data is BUS_WIDTH*8 bits.
- READY_MODE, 0, 0 = tready high whenever enabled; 1 = tready driven by the LFSR pattern.
- LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
- aclk  in  1  stream clock; all logic on rising edge.
- arstn  in  1  asynchronous active-low reset.
- enable  in  1  checker enable; when low, no beats are accepted.
- clear  in  1  synchronous clear of status/counters and resync.
- s_axis_tdata  in  BUS_WIDTH*8  stream data.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready (registered).
- locked  out  1  first beat received since enable/clear.
- error  out  1  sticky mismatch flag.
- err_count  out  32  mismatch count, saturating.
- beat_count  out  32  accepted beat count, saturating.
- err_expected  out  BUS_WIDTH*8  expected value at first mismatch.
- err_received  out  BUS_WIDTH*8  received value at first mismatch.

Behaviour:
- Reset (arstn low, asynchronous):
  - s_axis_tready=0, locked=0, error=0, all counters and captures 0.
  - lfsr=LFSR_SEED; state=IDLE.
- Handshake definition: a beat transfers at a rising edge where s_axis_tvalid & s_axis_tready are both high. Data is sampled only at that edge.
- LFSR:
  - 16-bit Galois, taps mask 16'hB400.
  - Advances every cycle while enable=1; holds otherwise.
- Ready generation:
  - Next s_axis_tready = enable & ~clear & (READY_MODE ? lfsr[0] : 1).
  - Registered, so it follows enable by one cycle.
  - s_axis_tready is never high in a cycle following one with enable=0.
- States:
  - IDLE: tready low; enable=1 -> SYNC.
  - SYNC: first handshake -> expected=data+1, beat_count=1, locked=1; go to CHECK. No comparison is made on this beat.
  - CHECK, matching beat (data==expected): expected+=1 with natural wrap; beat_count+=1.
  - CHECK, mismatching beat: error=1, err_count+=1, beat_count+=1.
    - err_expected/err_received are captured only while error was 0 (first mismatch only).
    - Resync: expected=data+1, so a single skip counts as exactly one error.
  - enable=0 in SYNC or CHECK -> IDLE next edge; locked cleared; counters, error and captures held.
- clear:
  - Takes priority over everything except reset.
  - Next edge: counters=0, error=0, captures=0, locked=0.
  - State -> SYNC if enable, else IDLE.
  - A beat handshaking on the clear edge is consumed but neither counted nor checked.
- Saturation: err_count and beat_count stop at 32'hFFFFFFFF; no wrap.
- Wrap: all-ones followed by 0 is a match, not an error.
- Arbitrary upstream valid behaviour is legal. The checker makes no assumption about valid stability while ready is low.

Test Plan:
1. READY_MODE=0, BUS_WIDTH=1: enable, send 0..299 continuously -> beat_count=300, error=0, locked=1; wrap 255->0 produces no error.
2. Send 5,6,7,9,10,11 -> error=1, err_count=1, err_expected=8, err_received=9, beat_count=6; no further errors after 9.
3. READY_MODE=1, seed 16'hACE1, source holds valid with incrementing data for 1000 beats -> tready follows lfsr[0] delayed one cycle, beat_count=1000, error=0; drop enable -> tready=0 from the next edge onward.
4. Stream starting at 8'h42 -> first beat locks with no error; beat_count=1 after the first beat. Next values 43,44 -> no error.
5. Mid-run clear pulse for one cycle while a beat handshakes -> beat_count=0, err_count=0, error=0, locked=0 next cycle. The next beat (any value) relocks without error.
6. arstn low mid-stream (asynchronous, between edges) -> tready, locked, error and counters go to 0 immediately. After release plus enable, the checker relocks on the next beat.
